sprite_engine: RTL and testbench

- Parametrised successor to the fixed two-sprite GPU path.
- Holds a run-time writable attribute table for NUM_SPRITES sprites: position, animation frame and enable.
- For every pixel coordinate it resolves the highest-priority opaque sprite pixel by reading SRAM through a pipelined fetch FSM, then presents one 8-bit colour per pixel period.
- Sits between VGA_controller (DrawX/DrawY), the SRAM passthrough and the colour output stage. Runs on the 100 MHz system clock with a pixel strobe.

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_hit_unit.sv | 19 +
 rtl/sprite_engine.sv | 113 +++++++++++
 tb/tb_sprite_engine.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared attribute record, fetch FSM states and sprite-sheet offset helper.
package sprite_pkg;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] frame;
    logic       en;
  } sprite_attr_t;
  typedef enum logic [1:0] {IDLE, MASK, FETCH, DONE} fetch_state_t;
  function automatic logic [19:0] sprite_off(input logic [7:0] frame, input logic [9:0] dy,
                                             input logic [9:0] dx, input int w, input int h);
    return 20'(frame) * 20'(w * h) + 20'(dy) * 20'(w) + 20'(dx);
  endfunction
endpackage

// File: rtl/sprite_hit_unit.sv
// sprite_hit_unit: coverage test and sheet offset of one sprite at the latched pixel.
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 20,
  parameter int SPRITE_H = 20
) (
  input  logic [9:0]   x,
  input  logic [9:0]   y,
  input  sprite_attr_t attr,
  output logic         hit,
  output logic [19:0]  off
);
  // 11-bit compares so a sprite hanging past column/row 1023 does not wrap
  assign hit = attr.en &&
               {1'b0, x} >= {1'b0, attr.x} && {1'b0, x} < {1'b0, attr.x} + 11'(SPRITE_W) &&
               {1'b0, y} >= {1'b0, attr.y} && {1'b0, y} < {1'b0, attr.y} + 11'(SPRITE_H);
  assign off = sprite_off(attr.frame, y - attr.y, x - attr.x, SPRITE_W, SPRITE_H);
endmodule

// File: rtl/sprite_engine.sv
// sprite_engine: attribute table plus per-pixel SRAM fetch resolving the top opaque sprite pixel.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES    = 4,
  parameter int          SPRITE_W       = 20,
  parameter int          SPRITE_H       = 20,
  parameter int          FRAME_W        = 4,
  parameter int          CLKS_PER_PIXEL = 4,
  parameter logic [19:0] BASE_ADDR      = 20'h00000,
  parameter logic [7:0]  TRANSPARENT    = 8'hFF,
  parameter logic [7:0]  BACKGROUND     = 8'h00
) (
  input  logic                           Clk,
  input  logic                           Reset_N,
  input  logic                           pixel_en,
  input  logic [9:0]                     DrawX,
  input  logic [9:0]                     DrawY,
  input  logic                           attr_we,
  input  logic [$clog2(NUM_SPRITES)-1:0] attr_idx,
  input  logic [9:0]                     attr_x,
  input  logic [9:0]                     attr_y,
  input  logic [FRAME_W-1:0]             attr_frame,
  input  logic                           attr_en,
  input  logic                           overrun_clr,
  output logic [19:0]                    mem_addr,
  output logic                           mem_rd,
  input  logic [15:0]                    mem_rdata,
  output logic [7:0]                     pixel_rgb,
  output logic                           pixel_hit,
  output logic                           overrun
);
  localparam int IW = $clog2(NUM_SPRITES);
  sprite_attr_t            tbl  [NUM_SPRITES];
  sprite_attr_t            snap [NUM_SPRITES];
  logic [19:0]             offs [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]  hits, mask;
  logic [9:0]              lx, ly;
  logic [7:0]              cyc, byte_in, res_rgb;
  logic                    res_hit, pend, pend_sel, issue, opaque, fetch_ovr, viol;
  logic [IW-1:0]           sel;
  fetch_state_t            state, next;
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit_unit #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_hit (
      .x(lx), .y(ly), .attr(snap[g]), .hit(hits[g]), .off(offs[g])
    );
  end
  always_comb begin
    sel = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) if (mask[i]) sel = IW'(i);
  end
  // a read issued in the cycle an opaque byte is found is simply left unchecked
  assign issue    = state == FETCH && |mask && int'(cyc) <= CLKS_PER_PIXEL - 2;
  assign byte_in  = pend_sel ? mem_rdata[15:8] : mem_rdata[7:0];
  assign opaque   = state == FETCH && pend && byte_in != TRANSPARENT;
  assign mem_rd   = issue;
  assign mem_addr = issue ? BASE_ADDR + {1'b0, offs[sel][19:1]} : '0;
  assign viol     = pixel_en && (state == MASK || state == FETCH);
  always_comb begin
    next      = state;
    fetch_ovr = 1'b0;
    if (pixel_en) next = MASK;
    else if (state == MASK) next = |hits ? FETCH : DONE;
    else if (state == FETCH && (opaque || !issue)) begin
      next      = DONE;
      fetch_ovr = !opaque && |mask;
    end
  end
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state     <= IDLE;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl[i]  <= '0;
        snap[i] <= '0;
      end
      lx        <= '0;
      ly        <= '0;
      mask      <= '0;
      cyc       <= '0;
      pend      <= 1'b0;
      pend_sel  <= 1'b0;
      res_rgb   <= BACKGROUND;
      res_hit   <= 1'b0;
      pixel_rgb <= BACKGROUND;
      pixel_hit <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state    <= next;
      if (attr_we && int'(attr_idx) < NUM_SPRITES)
        tbl[attr_idx] <= '{x: attr_x, y: attr_y, frame: 8'(attr_frame), en: attr_en};
      cyc      <= pixel_en ? 8'd1 : cyc + 8'(cyc != 8'hFF);
      pend     <= issue && !pixel_en;
      pend_sel <= offs[sel][0];
      if (pixel_en) begin
        lx        <= DrawX;
        ly        <= DrawY;
        snap      <= tbl;
        pixel_rgb <= state == DONE ? res_rgb : BACKGROUND;
        pixel_hit <= state == DONE && res_hit;
      end
      if (state == MASK) mask <= hits;
      else if (issue) mask <= mask & (mask - 1'b1);
      if (state == MASK) begin
        res_rgb <= BACKGROUND;
        res_hit <= 1'b0;
      end else if (opaque) begin
        res_rgb <= byte_in;
        res_hit <= 1'b1;
      end
      overrun  <= (fetch_ovr || viol) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
    end
  end
endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: randomized pixels and attribute writes checked against a per-pixel reference model.
module tb_sprite_engine;
  localparam int NS = 3, CPP = 5, R = CPP - 3;
  logic        Clk = 0, Reset_N = 0, pixel_en = 0, attr_we = 0, attr_en = 0, overrun_clr = 0;
  logic [9:0]  DrawX = 0, DrawY = 0, attr_x = 0, attr_y = 0;
  logic [1:0]  attr_idx = 0;
  logic [3:0]  attr_frame = 0;
  logic [19:0] mem_addr;
  logic        mem_rd, pixel_hit, overrun;
  logic [15:0] mem_rdata = 0;
  logic [7:0]  pixel_rgb;
  sprite_engine #(.NUM_SPRITES(NS), .SPRITE_W(20), .SPRITE_H(20), .FRAME_W(4),
                  .CLKS_PER_PIXEL(CPP), .BASE_ADDR(20'h00000), .TRANSPARENT(8'hFF),
                  .BACKGROUND(8'h00)) dut (
    .Clk(Clk), .Reset_N(Reset_N), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .attr_we(attr_we), .attr_idx(attr_idx), .attr_x(attr_x), .attr_y(attr_y),
    .attr_frame(attr_frame), .attr_en(attr_en), .overrun_clr(overrun_clr),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .pixel_rgb(pixel_rgb), .pixel_hit(pixel_hit), .overrun(overrun)
  );
  always #5 Clk = ~Clk;
  logic [15:0] mem [4096];
  int total = 0, bad = 0;
  int tx[NS], ty[NS], tf[NS];
  bit te[NS];
  bit rd_q = 0;
  int a_q = 0;
  int rq[$], p_reads[$];
  logic [7:0] p_rgb = 0;
  bit p_hit = 0, m_ovr = 0;
  always @(negedge Clk) begin
    rd_q = mem_rd;
    a_q  = int'(mem_addr);
    if (mem_rd) rq.push_back(int'(mem_addr));
  end
  always @(posedge Clk) if (rd_q) mem_rdata <= mem[a_q % 4096];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // covering sprites in priority order; only the first R reads fit in one pixel period
  task automatic model_pixel(input int x, input int y, output bit ovr);
    int la[$];
    int ls[$];
    int n, nr, off;
    logic [15:0] w;
    logic [7:0] b;
    for (int s = 0; s < NS; s++)
      if (te[s] && x >= tx[s] && x < tx[s] + 20 && y >= ty[s] && y < ty[s] + 20) begin
        off = tf[s] * 400 + (y - ty[s]) * 20 + (x - tx[s]);
        la.push_back(off / 2);
        ls.push_back(off % 2);
      end
    n = la.size() < R ? la.size() : R;
    nr = n;
    p_rgb = 8'h00;
    p_hit = 0;
    for (int k = 0; k < n; k++) begin
      w = mem[la[k] % 4096];
      b = ls[k] == 1 ? w[15:8] : w[7:0];
      if (b != 8'hFF) begin
        p_rgb = b;
        p_hit = 1;
        nr = (k + 2 < n) ? k + 2 : n;
        break;
      end
    end
    ovr = !p_hit && la.size() > R;
    p_reads.delete();
    for (int k = 0; k < nr; k++) p_reads.push_back(la[k]);
  endtask
  task automatic model_wr(input int i, input int x, input int y, input int f, input bit e);
    if (i < NS) begin
      tx[i] = x; ty[i] = y; tf[i] = f; te[i] = e;
    end
  endtask
  task automatic wr(input int i, input int x, input int y, input int f, input bit e);
    @(negedge Clk);
    attr_we = 1; attr_idx = 2'(i); attr_x = 10'(x); attr_y = 10'(y); attr_frame = 4'(f); attr_en = e;
    @(negedge Clk);
    attr_we = 0;
    model_wr(i, x, y, f, e);
  endtask
  task automatic np(input int x, input int y, input bit clr = 0, input bit cw = 0,
                    input int ci = 0, input int cx = 0, input int cy = 0, input int cf = 0,
                    input bit ce = 0);
    bit ovr;
    @(negedge Clk);
    DrawX = 10'(x); DrawY = 10'(y); pixel_en = 1;
    if (cw) begin
      attr_we = 1; attr_idx = 2'(ci); attr_x = 10'(cx); attr_y = 10'(cy);
      attr_frame = 4'(cf); attr_en = ce;
    end
    @(negedge Clk);
    pixel_en = 0; attr_we = 0;
    check("rgb", 32'(pixel_rgb), 32'(p_rgb));
    check("hit", 32'(pixel_hit), 32'(p_hit));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("nreads", 32'(rq.size()), 32'(p_reads.size()));
    for (int i = 0; i < rq.size() && i < p_reads.size(); i++) check("rd_addr", 32'(rq[i]), 32'(p_reads[i]));
    rq.delete();
    model_pixel(x, y, ovr);
    if (cw) model_wr(ci, cx, cy, cf, ce);
    if (clr) begin
      overrun_clr = 1;
      m_ovr = 0;
    end
    m_ovr |= ovr;
    @(negedge Clk);
    overrun_clr = 0;
    repeat (CPP - 3) @(negedge Clk);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = {($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom),
                ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom)};
    mem[0] = 16'h3C1E;
    mem[400] = 16'h00FF; mem[600] = 16'h0042;
    mem[1000] = 16'h00FF; mem[800] = 16'h0077;
    mem[221] = 16'hAB00;
    mem[32] = 16'h5500;
    for (int i = 0; i < NS; i++) model_wr(i, 0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    check("rst_rgb", 32'(pixel_rgb), 32'h00);
    check("rst_hit", 32'(pixel_hit), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_rd", 32'(mem_rd), 32'h0);
    Reset_N = 1;
    np(5, 5);
    wr(0, 25, 10, 0, 1);
    np(25, 10);
    np(26, 10);
    wr(0, 100, 100, 2, 1);
    wr(1, 100, 100, 3, 1);
    np(100, 100);
    wr(1, 100, 100, 5, 1);
    wr(2, 100, 100, 4, 1);
    np(100, 100);
    np(0, 0, 1);
    np(0, 0);
    wr(0, 0, 0, 0, 0);
    wr(1, 0, 0, 0, 0);
    wr(2, 200, 50, 1, 1);
    np(203, 52);
    wr(0, 1010, 0, 0, 1);
    np(1015, 3);
    np(1015, 3, 0, 1, 0, 1010, 0, 0, 0);
    np(1015, 3);
    wr(3, 5, 5, 0, 1);
    np(5, 5);
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 2) == 0)
        wr($urandom_range(0, 3), $urandom_range(0, 80), $urandom_range(0, 80),
           $urandom_range(0, 15), 1'($urandom_range(0, 3) != 0));
      np($urandom_range(0, 100), $urandom_range(0, 100), 1'($urandom_range(0, 7) == 0),
         1'($urandom_range(0, 9) == 0), $urandom_range(0, 3), $urandom_range(0, 80),
         $urandom_range(0, 80), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end
    wr(0, 300, 300, 0, 1);
    np(300, 300);
    np(300, 300);
    @(negedge Clk);
    DrawX = 300; DrawY = 300; pixel_en = 1;
    @(negedge Clk);
    pixel_en = 0;
    @(posedge Clk);
    #1 check("fetch_rd", 32'(mem_rd), 32'h1);
    #1 Reset_N = 0;
    #1;
    check("arst_rd", 32'(mem_rd), 32'h0);
    check("arst_addr", 32'(mem_addr), 32'h0);
    check("arst_rgb", 32'(pixel_rgb), 32'h00);
    check("arst_hit", 32'(pixel_hit), 32'h0);
    check("arst_ovr", 32'(overrun), 32'h0);
    @(negedge Clk);
    Reset_N = 1;
    for (int i = 0; i < NS; i++) model_wr(i, 0, 0, 0, 0);
    m_ovr = 0; p_rgb = 0; p_hit = 0;
    p_reads.delete();
    rq.delete();
    np(300, 300);
    np(300, 300);
    np(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
